// File: rtl/mem_responder_512x32.sv
// Latency-programmable memory responder for the MAR/MDR interface.
// One access per request assertion, plus an IDLE-only preload port.
module mem_responder_512x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 9,
  parameter int LATENCY    = 2
) (
  input  logic                  Clock,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  read,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] data_in,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  ready,
  output logic                  busy,
  output logic                  err,
  input  logic                  overide,
  input  logic [ADDR_WIDTH-1:0] overide_address,
  input  logic [DATA_WIDTH-1:0] overide_data_in
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;
  localparam int CW    = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    DONE,
    HOLD
  } state_e;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  state_e                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  wr_op_q, wr_op_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  err_q, err_d;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_wa;
  logic [DATA_WIDTH-1:0] mem_wd;
  logic                  req;

  assign req = enable && (read || write);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wr_op_d = wr_op_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    ready_d = 1'b0;
    busy_d  = busy_q;
    err_d   = 1'b0;
    mem_we  = 1'b0;
    mem_wa  = addr_q;
    mem_wd  = wdata_q;
    case (state_q)
      IDLE: begin
        if (overide) begin
          mem_we = 1'b1;
          mem_wa = overide_address;
          mem_wd = overide_data_in;
        end else if (enable && read && write) begin
          err_d = 1'b1;
        end else if (req) begin
          addr_d  = address;
          wr_op_d = write;
          wdata_d = data_in;
          cnt_d   = CW'(LATENCY - 1);
          busy_d  = 1'b1;
          state_d = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - CW'(1);
        end else begin
          if (wr_op_q) mem_we = 1'b1;
          else dout_d = mem_q[addr_q];
          ready_d = 1'b1;
          busy_d  = 1'b0;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = req ? HOLD : IDLE;
      end
      HOLD: begin
        if (!req) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge Clock) begin
    if (clear) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wr_op_q <= 1'b0;
      wdata_q <= '0;
      dout_q  <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wr_op_q <= wr_op_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
    end
  end

  // Array is never reset; clear only suppresses an in-flight write.
  always_ff @(posedge Clock) begin
    if (mem_we && !clear) mem_q[mem_wa] <= mem_wd;
  end

  assign data_out = dout_q;
  assign ready    = ready_q;
  assign busy     = busy_q;
  assign err      = err_q;

endmodule

// File: tb/tb_mem_responder_512x32.sv
// Directed bench for mem_responder_512x32 (LATENCY=2).
// Per-cycle vector table plus hand sequences for HOLD behaviour.
module tb_mem_responder_512x32;

  logic        Clock = 1'b0;
  logic        clear, enable, read, write, overide;
  logic [8:0]  address, overide_address;
  logic [31:0] data_in, overide_data_in, data_out;
  logic        ready, busy, err;

  int checks = 0;
  int failures = 0;

  always #5 Clock = ~Clock;

  mem_responder_512x32 #(
    .DATA_WIDTH(32),
    .ADDR_WIDTH(9),
    .LATENCY(2)
  ) dut (
    .Clock(Clock),
    .clear(clear),
    .enable(enable),
    .read(read),
    .write(write),
    .address(address),
    .data_in(data_in),
    .data_out(data_out),
    .ready(ready),
    .busy(busy),
    .err(err),
    .overide(overide),
    .overide_address(overide_address),
    .overide_data_in(overide_data_in)
  );

  typedef struct {
    logic        clr;
    logic        ovr;
    logic [8:0]  oa;
    logic [31:0] od;
    logic        en;
    logic        rd;
    logic        wr;
    logic [8:0]  a;
    logic [31:0] d;
    logic [31:0] xdo;
    logic        xr;
    logic        xb;
    logic        xe;
  } vec_t;

  vec_t vq[$];

  task automatic drive(input logic clr, input logic ovr,
                       input logic [8:0] oa, input logic [31:0] od,
                       input logic en, input logic rd, input logic wr,
                       input logic [8:0] a, input logic [31:0] d);
    clear = clr;
    overide = ovr;
    overide_address = oa;
    overide_data_in = od;
    enable = en;
    read = rd;
    write = wr;
    address = a;
    data_in = d;
  endtask

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  initial begin
    int pulses;
    int first;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);

    //           clr ovr oa     od            en rd wr a      d             dout          r  b  e
    vq.push_back('{1, 0, 9'h0,  32'h0,        0, 0, 0, 9'h0,  32'h0,        32'h0,        0, 0, 0});
    vq.push_back('{0, 1, 9'h5,  32'hDEADBEEF, 0, 0, 0, 9'h0,  32'h0,        32'h0,        0, 0, 0});
    vq.push_back('{0, 1, 9'h10, 32'h0,        0, 0, 0, 9'h0,  32'h0,        32'h0,        0, 0, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 1, 0, 9'h5,  32'h0,        32'h0,        0, 1, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 1, 0, 9'h5,  32'h0,        32'h0,        0, 1, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 1, 0, 9'h5,  32'h0,        32'hDEADBEEF, 1, 0, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        0, 0, 0, 9'h0,  32'h0,        32'hDEADBEEF, 0, 0, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 0, 1, 9'h1FF,32'h12345678, 32'hDEADBEEF, 0, 1, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 0, 1, 9'h1FF,32'h12345678, 32'hDEADBEEF, 0, 1, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 0, 1, 9'h1FF,32'h12345678, 32'hDEADBEEF, 1, 0, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        0, 0, 0, 9'h0,  32'h0,        32'hDEADBEEF, 0, 0, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 1, 0, 9'h1FF,32'h0,        32'hDEADBEEF, 0, 1, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 1, 0, 9'h1FF,32'h0,        32'hDEADBEEF, 0, 1, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 1, 0, 9'h1FF,32'h0,        32'h12345678, 1, 0, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        0, 0, 0, 9'h0,  32'h0,        32'h12345678, 0, 0, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 1, 1, 9'h10, 32'hFFFFFFFF, 32'h12345678, 0, 0, 1});
    vq.push_back('{0, 0, 9'h0,  32'h0,        0, 0, 0, 9'h0,  32'h0,        32'h12345678, 0, 0, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 0, 1, 9'h10, 32'hAAAA5555, 32'h12345678, 0, 1, 0});
    vq.push_back('{1, 0, 9'h0,  32'h0,        1, 0, 1, 9'h10, 32'hAAAA5555, 32'h0,        0, 0, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        0, 0, 0, 9'h0,  32'h0,        32'h0,        0, 0, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 1, 0, 9'h10, 32'h0,        32'h0,        0, 1, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 1, 0, 9'h10, 32'h0,        32'h0,        0, 1, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 1, 0, 9'h10, 32'h0,        32'h0,        1, 0, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        0, 0, 0, 9'h0,  32'h0,        32'h0,        0, 0, 0});
    vq.push_back('{0, 1, 9'h20, 32'hCAFEF00D, 1, 1, 0, 9'h20, 32'h0,        32'h0,        0, 0, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 1, 0, 9'h20, 32'h0,        32'h0,        0, 1, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 1, 0, 9'h20, 32'h0,        32'h0,        0, 1, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        1, 1, 0, 9'h20, 32'h0,        32'hCAFEF00D, 1, 0, 0});
    vq.push_back('{0, 0, 9'h0,  32'h0,        0, 0, 0, 9'h0,  32'h0,        32'hCAFEF00D, 0, 0, 0});

    foreach (vq[i]) begin
      drive(vq[i].clr, vq[i].ovr, vq[i].oa, vq[i].od,
            vq[i].en, vq[i].rd, vq[i].wr, vq[i].a, vq[i].d);
      tick();
      chk($sformatf("vec%0d", i),
          64'({data_out, ready, busy, err}),
          64'({vq[i].xdo, vq[i].xr, vq[i].xb, vq[i].xe}));
    end

    // Held read of 0x005 with a stray override during ACCESS.
    drive(0, 0, 0, 0, 1, 1, 0, 9'h5, 0);
    tick();
    chk("hold_accept_busy", 64'(busy), 64'(1));
    drive(0, 1, 9'h5, 32'h11111111, 1, 1, 0, 9'h5, 0);
    tick();
    chk("hold_access_rdy", 64'({ready, busy}), 64'({1'b0, 1'b1}));
    drive(0, 0, 0, 0, 1, 1, 0, 9'h5, 0);
    tick();
    chk("hold_first_rdy", 64'({ready, data_out}),
        64'({1'b1, 32'hDEADBEEF}));
    pulses = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ready) pulses++;
      chk($sformatf("hold_busy%0d", i), 64'(busy), 64'(0));
    end
    chk("hold_no_repulse", 64'(pulses), 64'(0));

    drive(0, 0, 0, 0, 1, 0, 0, 9'h5, 0);
    tick();
    drive(0, 0, 0, 0, 1, 1, 0, 9'h5, 0);
    pulses = 0;
    first = -1;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (ready) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
    chk("rearm_pulses", 64'(pulses), 64'(1));
    chk("rearm_latency", 64'(first), 64'(2));
    chk("ovr_ignored", 64'(data_out), 64'(32'hDEADBEEF));
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("final_idle", 64'({ready, busy, err}), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
